// File: rtl/pc_seq_ctrl.sv
// Instruction-sequencing controller: owns the PC, fetches over a valid/ready
// request channel, waits for execute completion, then applies redirects.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exu_done,
    input  logic        jmp_en,
    input  logic        jmpr_en,
    input  logic        jmpb_en,
    input  logic [31:0] offset,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        retire,
    output logic [31:0] retire_cnt,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH_REQ  = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_EXEC       = 3'd3,
        S_HALT       = 3'd4,
        S_ERROR      = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      cur, nxt;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        retire_q, retire_d;

    logic [31:0] rel_tgt;
    logic [31:0] next_pc;
    logic        misalign;

    // jal and taken branches share the pc-relative adder; sums wrap mod 2^32
    assign rel_tgt = pc_q + {offset[30:0], 1'b0};

    always_comb begin
        next_pc = pc_q + 32'd4;
        if (jmp_en)
            next_pc = rel_tgt;
        else if (jmpr_en)
            next_pc = {offset[31:1], 1'b0};
        else if (jmpb_en)
            next_pc = rel_tgt;
    end

    assign misalign = (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= S_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            retire_q <= 1'b0;
        end else begin
            cur      <= nxt;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        nxt      = cur;
        pc_d     = pc_q;
        inst_d   = inst_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        retire_d = 1'b0;
        case (cur)
            S_IDLE: nxt = S_FETCH_REQ;
            S_FETCH_REQ: begin
                if (imem_req_ready) begin
                    nxt   = S_FETCH_WAIT;
                    tmo_d = '0;
                end
            end
            S_FETCH_WAIT: begin
                // a response wins over a timeout landing on the same cycle
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        nxt = S_ERROR;
                    end else begin
                        inst_d = imem_rsp_data;
                        nxt    = S_EXEC;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    nxt = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (exu_done) begin
                    if (halt_req) begin
                        nxt      = S_HALT;
                        retire_d = 1'b1;
                        cnt_d    = cnt_q + 32'd1;
                    end else if (misalign) begin
                        nxt = S_ERROR;
                    end else begin
                        nxt      = S_FETCH_REQ;
                        pc_d     = next_pc;
                        retire_d = 1'b1;
                        cnt_d    = cnt_q + 32'd1;
                    end
                end
            end
            S_HALT:  nxt = S_HALT;
            S_ERROR: nxt = S_ERROR;
            default: nxt = S_IDLE;
        endcase
    end

    assign imem_req_valid = (cur == S_FETCH_REQ);
    assign imem_req_addr  = pc_q;
    assign inst           = inst_q;
    assign inst_valid     = (cur == S_EXEC);
    assign pc             = pc_q;
    assign state          = cur;
    assign retire         = retire_q;
    assign retire_cnt     = cnt_q;
    assign fault          = (cur == S_ERROR);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: sequential fetch, backpressure, redirects,
// faults, halt and mid-fetch reset, all against hand-computed values.
module tb_pc_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exu_done;
    logic        jmp_en;
    logic        jmpr_en;
    logic        jmpb_en;
    logic [31:0] offset;
    logic        halt_req;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        retire;
    logic [31:0] retire_cnt;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int a0, a1, a2;
    logic seen;

    pc_seq_ctrl #(.RESET_PC(32'h8000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst(inst), .inst_valid(inst_valid), .exu_done(exu_done),
        .jmp_en(jmp_en), .jmpr_en(jmpr_en), .jmpb_en(jmpb_en),
        .offset(offset), .halt_req(halt_req),
        .pc(pc), .state(state), .retire(retire), .retire_cnt(retire_cnt),
        .fault(fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_in();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
        exu_done = 0; jmp_en = 0; jmpr_en = 0; jmpb_en = 0; offset = 0; halt_req = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_in();
        step();
        rst = 0;
        step();
    endtask

    // Present the request (optionally stalled) and accept it.
    task automatic accept(input logic [31:0] addr, input int stall);
        check("fr_state", 32'(state), 32'd1);
        for (int i = 0; i < stall; i++) begin
            imem_req_ready = 0;
            check("bp_valid", 32'(imem_req_valid), 32'd1);
            check("bp_addr", imem_req_addr, addr);
            check("bp_state", 32'(state), 32'd1);
            step();
        end
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_req_addr, addr);
        imem_req_ready = 1;
        acc_cyc = cyc;
        step();
        imem_req_ready = 0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int stall, input int lat);
        accept(addr, stall);
        for (int i = 0; i < lat; i++) begin
            check("fw_state", 32'(state), 32'd2);
            check("fw_valid", 32'(imem_req_valid), 32'd0);
            step();
        end
        imem_rsp_valid = 1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 0;
        check("ex_state", 32'(state), 32'd3);
        check("ex_inst", inst, data);
        check("ex_iv", 32'(inst_valid), 32'd1);
    endtask

    task automatic exec(input logic j, input logic jr, input logic jb,
                        input logic [31:0] off, input logic h, input int dly);
        for (int i = 0; i < dly; i++) begin
            check("hold_iv", 32'(inst_valid), 32'd1);
            check("hold_state", 32'(state), 32'd3);
            step();
        end
        exu_done = 1; jmp_en = j; jmpr_en = jr; jmpb_en = jb; offset = off; halt_req = h;
        step();
        exu_done = 0; jmp_en = 0; jmpr_en = 0; jmpb_en = 0; offset = 0; halt_req = 0;
    endtask

    task automatic post(input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        check("post_state", 32'(state), 32'd1);
        check("post_retire", 32'(retire), 32'd1);
        check("post_pc", pc, exp_pc);
        check("post_addr", imem_req_addr, exp_pc);
        check("post_cnt", retire_cnt, exp_cnt);
        check("post_iv", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        rst = 1;
        clear_in();
        step();
        step();
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_state", 32'(state), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_iv", 32'(inst_valid), 32'd0);
        check("rst_reqv", 32'(imem_req_valid), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_cnt", retire_cnt, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 0;
        check("idle", 32'(state), 32'd0);
        step();

        // sequential fetch, response one cycle after accept
        fetch(32'h8000_0000, 32'h0000_0013, 0, 1); a0 = acc_cyc;
        exec(0, 0, 0, 0, 0, 0);
        post(32'h8000_0004, 32'd1);
        fetch(32'h8000_0004, 32'h0010_0093, 0, 1); a1 = acc_cyc;
        check("period1", 32'(a1 - a0), 32'd4);
        exec(0, 0, 0, 0, 0, 0);
        post(32'h8000_0008, 32'd2);
        fetch(32'h8000_0008, 32'h0020_0113, 0, 1); a2 = acc_cyc;
        check("period2", 32'(a2 - a1), 32'd4);
        exec(0, 0, 0, 0, 0, 0);
        post(32'h8000_000C, 32'd3);

        // backpressure, slow execute
        fetch(32'h8000_000C, 32'h1234_5678, 5, 0);
        check("bp_pc", pc, 32'h8000_000C);
        exec(0, 0, 0, 0, 0, 3);
        post(32'h8000_0010, 32'd4);

        // redirects
        do_reset();
        fetch(32'h8000_0000, 32'hAAAA_0001, 0, 0);
        imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 0;
        check("drop_inst", inst, 32'hAAAA_0001);
        check("drop_state", 32'(state), 32'd3);
        exec(1, 0, 0, 32'h0000_0010, 0, 0);
        post(32'h8000_0020, 32'd1);
        fetch(32'h8000_0020, 32'hAAAA_0002, 0, 0);
        exec(0, 0, 1, 32'hFFFF_FFF8, 0, 0);
        post(32'h8000_0010, 32'd2);
        fetch(32'h8000_0010, 32'hAAAA_0003, 0, 0);
        exec(0, 1, 0, 32'h8000_0101, 0, 0);
        post(32'h8000_0100, 32'd3);
        fetch(32'h8000_0100, 32'hAAAA_0004, 0, 0);
        exec(1, 1, 0, 32'h0000_0008, 0, 0);
        post(32'h8000_0110, 32'd4);

        // misaligned jalr target
        fetch(32'h8000_0110, 32'hAAAA_0005, 0, 0);
        exec(0, 1, 0, 32'h8000_0002, 0, 0);
        check("mis_state", 32'(state), 32'd5);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_pc", pc, 32'h8000_0110);
        check("mis_retire", 32'(retire), 32'd0);
        check("mis_cnt", retire_cnt, 32'd4);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            imem_req_ready = 1;
            step();
            seen = seen | imem_req_valid | inst_valid;
        end
        imem_req_ready = 0;
        check("mis_quiet", 32'(seen), 32'd0);
        check("mis_sticky", 32'(state), 32'd5);

        // response carrying a bus error
        do_reset();
        accept(32'h8000_0000, 0);
        imem_rsp_valid = 1; imem_rsp_err = 1; imem_rsp_data = 32'h0000_0013;
        step();
        imem_rsp_valid = 0; imem_rsp_err = 0;
        check("err_state", 32'(state), 32'd5);
        check("err_fault", 32'(fault), 32'd1);
        check("err_pc", pc, 32'h8000_0000);

        // timeout after 16 silent wait cycles
        do_reset();
        accept(32'h8000_0000, 0);
        repeat (15) step();
        check("tmo_wait15", 32'(state), 32'd2);
        step();
        check("tmo_state", 32'(state), 32'd5);
        check("tmo_fault", 32'(fault), 32'd1);

        // response on the 16th wait cycle is accepted, then halt
        do_reset();
        fetch(32'h8000_0000, 32'h0010_0073, 0, 15);
        exec(1, 0, 0, 32'h0000_0040, 1, 0);
        check("halt_state", 32'(state), 32'd4);
        check("halt_retire", 32'(retire), 32'd1);
        check("halt_cnt", retire_cnt, 32'd1);
        check("halt_pc", pc, 32'h8000_0000);
        check("halt_fault", 32'(fault), 32'd0);
        step();
        check("halt_retire_once", 32'(retire), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            imem_req_ready = 1;
            step();
            seen = seen | imem_req_valid | inst_valid | retire | (state != 3'd4);
        end
        imem_req_ready = 0;
        check("halt_quiet", 32'(seen), 32'd0);
        check("halt_pc_frozen", pc, 32'h8000_0000);

        // reset during an outstanding fetch
        do_reset();
        fetch(32'h8000_0000, 32'h0000_0013, 0, 0);
        exec(0, 0, 0, 0, 0, 0);
        post(32'h8000_0004, 32'd1);
        accept(32'h8000_0004, 0);
        check("mid_wait", 32'(state), 32'd2);
        rst = 1;
        #1;
        check("mid_pc", pc, 32'h8000_0000);
        check("mid_state", 32'(state), 32'd0);
        check("mid_cnt", retire_cnt, 32'd0);
        step();
        rst = 0;
        check("mid_idle", 32'(state), 32'd0);
        step();
        check("mid_fr", 32'(state), 32'd1);
        check("mid_addr", imem_req_addr, 32'h8000_0000);
        check("mid_iv", 32'(inst_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
